// File: rtl/interp_bilineal_seq.sv
// rtl/interp_bilineal_seq.sv - sequential bilinear interpolator sharing one 17x9 multiplier
// One multiply-accumulate per state; result emitted 7 edges after the request is sampled.
module interp_bilineal_seq #(
  parameter int ROUND = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [7:0] I00,
  input  logic [7:0] I10,
  input  logic [7:0] I01,
  input  logic [7:0] I11,
  input  logic [7:0] alpha,
  input  logic [7:0] beta,
  output logic       valid_out,
  output logic [7:0] pixel_out,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_B0, S_B1, S_V0, S_V1, S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  i00_q, i10_q, i01_q, i11_q, alpha_q, beta_q;
  logic [7:0]  i00_d, i10_d, i01_d, i11_d, alpha_d, beta_d;
  logic [15:0] top_q, top_d, bot_q, bot_d;
  logic [24:0] acc_q, acc_d;
  logic [7:0]  pixel_q, pixel_d;
  logic        valid_q, valid_d;

  logic [8:0]  inv_alpha, inv_beta;
  logic [16:0] mul_a;
  logic [8:0]  mul_b;
  logic [24:0] prod;
  logic [9:0]  pix_wide;

  assign inv_alpha = 9'd256 - {1'b0, alpha_q};
  assign inv_beta  = 9'd256 - {1'b0, beta_q};

  // The single shared multiplier; the widest product (65280*256) fits in 25 bits.
  assign prod = 25'(mul_a * mul_b);

  assign pix_wide = 10'((26'(acc_q) + ((ROUND != 0) ? 26'd32768 : 26'd0)) >> 16);

  always_comb begin
    state_d = state_q;
    i00_d   = i00_q;
    i10_d   = i10_q;
    i01_d   = i01_q;
    i11_d   = i11_q;
    alpha_d = alpha_q;
    beta_d  = beta_q;
    top_d   = top_q;
    bot_d   = bot_q;
    acc_d   = acc_q;
    pixel_d = pixel_q;
    valid_d = 1'b0;
    mul_a   = '0;
    mul_b   = '0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          i00_d   = I00;
          i10_d   = I10;
          i01_d   = I01;
          i11_d   = I11;
          alpha_d = alpha;
          beta_d  = beta;
          state_d = S_T0;
        end
      end
      S_T0: begin
        mul_a   = {9'd0, i00_q};
        mul_b   = inv_alpha;
        top_d   = prod[15:0];
        state_d = S_T1;
      end
      S_T1: begin
        mul_a   = {9'd0, i10_q};
        mul_b   = {1'b0, alpha_q};
        top_d   = top_q + prod[15:0];
        state_d = S_B0;
      end
      S_B0: begin
        mul_a   = {9'd0, i01_q};
        mul_b   = inv_alpha;
        bot_d   = prod[15:0];
        state_d = S_B1;
      end
      S_B1: begin
        mul_a   = {9'd0, i11_q};
        mul_b   = {1'b0, alpha_q};
        bot_d   = bot_q + prod[15:0];
        state_d = S_V0;
      end
      S_V0: begin
        mul_a   = {1'b0, top_q};
        mul_b   = inv_beta;
        acc_d   = prod;
        state_d = S_V1;
      end
      S_V1: begin
        mul_a   = {1'b0, bot_q};
        mul_b   = {1'b0, beta_q};
        acc_d   = acc_q + prod;
        state_d = S_OUT;
      end
      S_OUT: begin
        pixel_d = (pix_wide > 10'd255) ? 8'hFF : pix_wide[7:0];
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      i00_q   <= '0;
      i10_q   <= '0;
      i01_q   <= '0;
      i11_q   <= '0;
      alpha_q <= '0;
      beta_q  <= '0;
      top_q   <= '0;
      bot_q   <= '0;
      acc_q   <= '0;
      pixel_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i00_q   <= i00_d;
      i10_q   <= i10_d;
      i01_q   <= i01_d;
      i11_q   <= i11_d;
      alpha_q <= alpha_d;
      beta_q  <= beta_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      acc_q   <= acc_d;
      pixel_q <= pixel_d;
      valid_q <= valid_d;
    end
  end

  assign valid_out = valid_q;
  assign pixel_out = pixel_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_interp_bilineal_seq.sv
// tb/tb_interp_bilineal_seq.sv - self-checking bench for interp_bilineal_seq
// Two instances (ROUND=1 and ROUND=0) share stimulus; a transaction-level model predicts outputs.
module tb_interp_bilineal_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in = 1'b0;
  logic [7:0] i00 = '0, i10 = '0, i01 = '0, i11 = '0, alpha = '0, beta = '0;
  logic       v1, b1, v0, b0;
  logic [7:0] p1, p0;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  interp_bilineal_seq #(.ROUND(1)) u_dut_r (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .I00(i00), .I10(i10), .I01(i01), .I11(i11), .alpha(alpha), .beta(beta),
    .valid_out(v1), .pixel_out(p1), .busy(b1)
  );

  interp_bilineal_seq #(.ROUND(0)) u_dut_t (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .I00(i00), .I10(i10), .I01(i01), .I11(i11), .alpha(alpha), .beta(beta),
    .valid_out(v0), .pixel_out(p0), .busy(b0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bilinear(input int a00, a10, a01, a11, al, be, input bit rnd);
    int top, bot, acc, r;
    top = a00 * (256 - al) + a10 * al;
    bot = a01 * (256 - al) + a11 * al;
    acc = top * (256 - be) + bot * be;
    r   = (acc + (rnd ? 32768 : 0)) / 65536;
    return (r > 255) ? 255 : r;
  endfunction

  // Transaction model: an accepted request yields its result 7 edges later; requests are
  // accepted only when nothing is in flight.
  int         remain = 0;
  int         pend1 = 0, pend0 = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_pix1 = '0, m_pix0 = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      remain  = 0;
      m_valid = 1'b0;
      m_pix1  = '0;
      m_pix0  = '0;
    end else begin
      m_valid = 1'b0;
      if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          m_valid = 1'b1;
          m_pix1  = 8'(pend1);
          m_pix0  = 8'(pend0);
        end
      end else if (valid_in) begin
        pend1  = bilinear(i00, i10, i01, i11, alpha, beta, 1'b1);
        pend0  = bilinear(i00, i10, i01, i11, alpha, beta, 1'b0);
        remain = 7;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("valid_out_r", v1, m_valid);
      check("valid_out_t", v0, m_valid);
      check("busy_r", b1, remain != 0);
      check("pixel_out_r", p1, m_pix1);
      check("pixel_out_t", p0, m_pix0);
    end
  end

  task automatic wait_valid(output int lat);
    lat = 13;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (v1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic directed(input string name, input int a00, a10, a01, a11, al, be,
                          input int exp_r, input int exp_t);
    int lat;
    check({name, "_model_r"}, bilinear(a00, a10, a01, a11, al, be, 1'b1), exp_r);
    check({name, "_model_t"}, bilinear(a00, a10, a01, a11, al, be, 1'b0), exp_t);
    @(negedge clk);
    i00 = 8'(a00); i10 = 8'(a10); i01 = 8'(a01); i11 = 8'(a11);
    alpha = 8'(al); beta = 8'(be); valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    i00 = 8'($urandom); i10 = 8'($urandom); i01 = 8'($urandom); i11 = 8'($urandom);
    alpha = 8'($urandom); beta = 8'($urandom);
    wait_valid(lat);
    check({name, "_latency"}, lat, 7);
    check({name, "_pix_r"}, p1, exp_r);
    check({name, "_pix_t"}, p0, exp_t);
  endtask

  initial begin
    int lat, cnt;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", v1, 0);
    check("reset_pixel", p1, 0);
    check("reset_busy", b1, 0);

    // First edge after reset release accepts the request.
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    i00 = 8'd100; valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    check("first_accept_busy", b1, 1);
    wait_valid(lat);
    check("first_latency", lat, 7);
    check("first_pix", p1, 100);

    directed("req030", 100, 0, 0, 0, 0, 0, 100, 100);
    directed("req031", 0, 255, 0, 0, 128, 0, 128, 127);
    directed("req032", 255, 255, 255, 255, 255, 255, 255, 255);
    directed("req033", 0, 0, 200, 200, 64, 192, 150, 150);

    // Request during busy is dropped; request in the valid_out cycle is accepted.
    @(negedge clk);
    i00 = 8'd10; i10 = 8'd20; i01 = 8'd30; i11 = 8'd40; alpha = 8'd0; beta = 8'd0;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i00 = 8'd250; i10 = 8'd250; i01 = 8'd250; i11 = 8'd250; valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    cnt = 3;
    lat = 13;
    for (int k = 4; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (v1) begin
        lat = k;
        break;
      end
    end
    check("busy_drop_latency", lat, 7);
    check("busy_drop_pix", p1, 10);
    i00 = 8'd0; i10 = 8'd0; i01 = 8'd200; i11 = 8'd200; alpha = 8'd64; beta = 8'd192;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    cnt = 13;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (v1) begin
        cnt = k;
        break;
      end
    end
    check("b2b_gap", cnt + 1, 8);
    check("b2b_pix", p1, 150);

    // Reset while in S_B1: outputs clear at once and the request never completes.
    @(negedge clk);
    i00 = 8'd77; i10 = 8'd77; i01 = 8'd77; i11 = 8'd77; valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_valid", v1, 0);
    check("abort_pixel", p1, 0);
    check("abort_busy", b1, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (v1) cnt++;
    end
    check("abort_no_valid", cnt, 0);

    // Randomised traffic including requests issued while busy.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        i00 = 8'hFF; i10 = 8'hFF; i01 = 8'hFF; i11 = 8'hFF;
        alpha = 8'($urandom_range(0, 1) * 255); beta = 8'($urandom_range(0, 1) * 255);
      end else begin
        i00 = 8'($urandom); i10 = 8'($urandom); i01 = 8'($urandom); i11 = 8'($urandom);
        alpha = 8'($urandom); beta = 8'($urandom);
      end
      valid_in = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/interp_bilineal_seq.md
INTERP_BILINEAL_SEQ -- requirements
Module: interp_bilineal_seq

Interface
REQ-001 Parameter: ROUND, default 1, 1 = round-half-up on final shift, 0 = truncate.
REQ-002 Port: clk  input  1  sole clock, rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: valid_in  input  1  single-cycle request strobe from the downscale controller.
REQ-005 Port: I00  input  8  neighbour at (y_l, x_l).
REQ-006 Port: I10  input  8  neighbour at (y_l, x_h).
REQ-007 Port: I01  input  8  neighbour at (y_h, x_l).
REQ-008 Port: I11  input  8  neighbour at (y_h, x_h).
REQ-009 Port: alpha  input  8  horizontal weight, unsigned Q0.8.
REQ-010 Port: beta  input  8  vertical weight, unsigned Q0.8.
REQ-011 Port: valid_out  output  1  one-cycle result strobe.
REQ-012 Port: pixel_out  output  8  interpolated pixel, held until next result.
REQ-013 Port: busy  output  1  high while a request is in progress.

Function
REQ-014 SHALL use exactly one 17x9-bit unsigned multiplier, shared across all products, one multiply-accumulate per cycle.
REQ-015 States SHALL be S_IDLE, S_T0, S_T1, S_B0, S_B1, S_V0, S_V1, S_OUT.
REQ-016 In S_IDLE with valid_in=1, SHALL register I00..I11, alpha and beta on that edge (E0) and go to S_T0; later input changes SHALL have no effect.
REQ-017 S_T0: top = I00*(256-alpha); S_T1: top += I10*alpha; 16-bit result, max 65280.
REQ-018 S_B0: bot = I01*(256-alpha); S_B1: bot += I11*alpha; 16-bit result.
REQ-019 S_V0: acc = top*(256-beta); S_V1: acc += bot*beta; acc SHALL be 25 bits, with no overflow.
REQ-020 S_OUT SHALL compute (acc + (ROUND ? 32768 : 0)) >> 16, clamp to 255, register pixel_out, set valid_out=1 and go to S_IDLE.
REQ-021 Latency SHALL be 7 edges: valid_in sampled at E0 -> valid_out high in the cycle after E7, cleared at E8.
REQ-022 busy SHALL equal (state != S_IDLE); it is high from after E0 through after E6.
REQ-023 valid_in while busy=1 SHALL be ignored, with no queueing and no effect on the in-flight result.
REQ-024 valid_in SHALL be accepted in the cycle valid_out is high (state is S_IDLE), allowing back-to-back requests every 8 cycles.
REQ-025 Weight 256-alpha SHALL be computed as a 9-bit value (alpha=0 -> 256).
REQ-026 pixel_out SHALL change only at an S_OUT edge or on reset.

Reset
REQ-027 rst=1 SHALL immediately force state=S_IDLE, valid_out=0, pixel_out=0, busy=0, and clear the top, bot and acc registers.
REQ-028 Reset mid-operation SHALL abort the request, with no valid_out for it after release.
REQ-029 The first valid_in SHALL be accepted on the first rising edge with rst=0.

Verification
REQ-030 I00=100, others=0, alpha=0, beta=0 -> pixel_out=100, valid_out exactly 7 edges after valid_in sample.
REQ-031 I00=0, I10=255, I01=0, I11=0, alpha=128, beta=0 -> pixel_out=128 (ROUND=1), 127 (ROUND=0).
REQ-032 All I=255, alpha=255, beta=255 -> pixel_out=255, with no wrap.
REQ-033 I00=I10=0, I01=I11=200, alpha=64, beta=192 -> pixel_out=150.
REQ-034 Second valid_in with different operands 3 cycles after first -> single valid_out carrying first result; then a request issued in the valid_out cycle completes 8 cycles after the first valid_out.
REQ-035 rst asserted at S_B1 -> outputs 0 immediately, no valid_out for 10 cycles after release absent new valid_in.
